// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-write buffer between the core data port and a
// variable-latency data memory. Stores are queued in a circular FIFO and
// drained in the background. A load is served from the newest matching
// queued store when there is one; otherwise the core stalls while the word
// is read from memory.
// Optional feature macro: WB_COALESCE_EN. When it is defined, a store to a
// word that is already queued overwrites that entry in place. The one
// exception is the head entry while its write is in flight.

module dmem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state;
    logic [29:0]   q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          full;
    logic          empty;
    logic          match_any;
    logic [PW-1:0] match_idx;
    logic          coal;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [PW:0]   count_nxt;
    logic          miss;
    logic          rd_done;
    logic [PW-1:0] issue_idx;
    logic          bypass;
    logic [29:0]   issue_addr;
    logic [31:0]   issue_data;
    logic          issue_rd;
    logic          issue_wr;
    logic          go_idle;
    logic          unused_addr_lsb;

    // Accesses are word-sized, so the byte offset carries no information.
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Scan the valid entries from oldest to newest; the last hit wins, so
    // the newest store to the word supplies the data.
    always_comb begin
        match_any = 1'b0;
        match_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count) && (q_addr[head + PW'(i)] == cpu_addr[31:2])) begin
                match_any = 1'b1;
                match_idx = head + PW'(i);
            end
        end
    end

`ifdef WB_COALESCE_EN
    // Merge into the newest match unless that entry is already on the bus.
    assign coal = cpu_we & match_any & ~((state == WRITE) & (match_idx == head));
`else
    assign coal = 1'b0;
`endif

    assign rd_done   = (state == READ) & mem_ready;
    assign miss      = cpu_re & ~match_any;
    assign push      = reset & cpu_we & ~full & ~coal;
    assign pop       = (state == WRITE) & mem_ready;
    assign wr_en     = push | (reset & coal);
    assign wr_idx    = coal ? match_idx : tail;
    assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);

    assign cpu_stall = reset & ((cpu_we & full & ~coal) | (miss & ~rd_done));

    // Load data: forwarded entry on a hit, memory data on read completion.
    always_comb begin
        cpu_rdata = '0;
        if (reset && cpu_re) begin
            if (match_any) begin
                cpu_rdata = q_data[match_idx];
            end else if (rd_done) begin
                cpu_rdata = mem_rdata;
            end
        end
    end

    // Pick the entry issued at this edge. If the store of this same cycle
    // writes that slot, take the incoming store directly so the bus never
    // carries stale data.
    always_comb begin
        issue_idx  = (state == WRITE) ? head + PW'(1) : head;
        bypass     = wr_en & (wr_idx == issue_idx);
        issue_addr = bypass ? cpu_addr[31:2] : q_addr[issue_idx];
        issue_data = bypass ? cpu_wdata : q_data[issue_idx];
    end

    // Decide what the memory port does at this edge. A read miss wins only
    // at issue points, so an in-flight write always finishes first.
    always_comb begin
        issue_rd = 1'b0;
        issue_wr = 1'b0;
        go_idle  = 1'b0;
        case (state)
            IDLE: begin
                if (miss) begin
                    issue_rd = 1'b1;
                end else if (!empty) begin
                    issue_wr = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (miss) begin
                        issue_rd = 1'b1;
                    end else if (count_nxt != '0) begin
                        issue_wr = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            READ: begin
                if (mem_ready) begin
                    if (count_nxt != '0) begin
                        issue_wr = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    // Queue storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_addr[wr_idx] <= cpu_addr[31:2];
            q_data[wr_idx] <= cpu_wdata;
        end
    end

    // FIFO pointers, controller state and the registered memory request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (issue_rd) begin
                state    <= READ;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {cpu_addr[31:2], 2'b00};
            end else if (issue_wr) begin
                state     <= WRITE;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {issue_addr, 2'b00};
                mem_wdata <= issue_data;
            end else if (go_idle) begin
                state   <= IDLE;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Testbench for dmem_write_buffer: directed stimulus, a queue-based model
// of pending stores plus a backing memory, and a per-cycle comparator.

module tb_dmem_write_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] memarr [0:1023];
    ent_t        mq[$];
    ent_t        wlog[$];
    int          checks = 0;
    int          errors = 0;

    dmem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = memarr[mem_addr[11:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((mq.size() != 0 || mem_req) && n < 60) begin
            tick();
            n++;
        end
        chk("drain within budget", 32'(n < 60), 1);
    endtask

    // Model and comparator: evaluated mid-cycle, then advanced to what the
    // coming rising edge must do.
    initial begin
        bit          exp_hit, coal_ok, inflight, rd_done, exp_stall, popped, prev_pending;
        int          ni;
        logic [31:0] exp_val;
        logic [31:0] p_addr, p_wdata;
        logic        p_req, p_we;
        ent_t        e;
        for (int i = 0; i < 1024; i++) memarr[i] = 32'h5A000000 | 32'(i);
        memarr[32'h300 >> 2] = 32'hCAFEF00D;
        memarr[32'h500 >> 2] = 32'h55550000;
        memarr[32'h604 >> 2] = 32'h66660004;
        prev_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("reset stall", cpu_stall, 0);
                chk("reset rdata", cpu_rdata, 0);
                chk("reset mem_req", mem_req, 0);
                mq.delete();
                prev_pending = 1'b0;
            end else begin
                exp_hit = 1'b0;
                ni      = 0;
                exp_val = memarr[cpu_addr[11:2]];
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].a[31:2] == cpu_addr[31:2]) begin
                        exp_hit = 1'b1;
                        ni      = i;
                        exp_val = mq[i].d;
                    end
                end
                inflight = mem_req & mem_we;
`ifdef WB_COALESCE_EN
                coal_ok = exp_hit && !(ni == 0 && inflight);
`else
                coal_ok = 1'b0;
`endif
                rd_done   = mem_req & ~mem_we & mem_ready;
                exp_stall = (cpu_we && mq.size() == DEPTH && !coal_ok) ||
                            (cpu_re && !exp_hit && !rd_done);
                chk("cycle stall", cpu_stall, exp_stall);
                chk("cycle rdata", cpu_rdata, (cpu_re && !exp_stall) ? exp_val : 32'h0);
                chk("mem_addr aligned", mem_addr[1:0], 0);
                if (mem_req && !mem_we) begin
                    chk("read only for a load", cpu_re, 1);
                    chk("read address", mem_addr, {cpu_addr[31:2], 2'b00});
                end
                if (prev_pending) begin
                    chk("hold mem_req", mem_req, p_req);
                    chk("hold mem_we", mem_we, p_we);
                    chk("hold mem_addr", mem_addr, p_addr);
                    chk("hold mem_wdata", mem_wdata, p_wdata);
                end
                popped = 1'b0;
                if (mem_req && mem_we && mem_ready) begin
                    chk("write has pending store", 32'(mq.size() != 0), 1);
                    if (mq.size() != 0) begin
                        chk("write order addr", mem_addr, mq[0].a);
                        chk("write order data", mem_wdata, mq[0].d);
                        void'(mq.pop_front());
                        popped = 1'b1;
                    end
                    memarr[mem_addr[11:2]] = mem_wdata;
                    e.a = mem_addr;
                    e.d = mem_wdata;
                    wlog.push_back(e);
                end
                if (cpu_we && !exp_stall) begin
                    if (coal_ok) begin
                        e   = mq[popped ? ni - 1 : ni];
                        e.d = cpu_wdata;
                        mq[popped ? ni - 1 : ni] = e;
                    end else begin
                        e.a = cpu_addr & 32'hFFFF_FFFC;
                        e.d = cpu_wdata;
                        mq.push_back(e);
                    end
                end
                prev_pending = mem_req && !mem_ready;
                p_req   = mem_req;
                p_we    = mem_we;
                p_addr  = mem_addr;
                p_wdata = mem_wdata;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   w0, n;
        ent_t e;
        cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0; mem_ready = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        cpu_re = 1; cpu_addr = 32'h100;
        repeat (2) tick();
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst stall with load", cpu_stall, 0);
        chk("rst rdata", cpu_rdata, 0);
        cpu_re = 0;
        tick();
        reset = 1'b1;
        tick();

        // Fill to full with memory not ready, then unblock with one pop.
        w0 = wlog.size();
        mem_ready = 0;
        for (int j = 0; j < 4; j++) begin
            cpu_we = 1; cpu_addr = 32'h100 + 32'(4 * j); cpu_wdata = 32'h10000000 + 32'(j);
            #1 chk("fill no stall", cpu_stall, 0);
            tick();
        end
        cpu_addr = 32'h110; cpu_wdata = 32'h10000004;
        #1 chk("full stall", cpu_stall, 1);
        chk("first write addr", mem_addr, 32'h100);
        chk("first write is write", mem_we, 1);
        tick();
        #1 chk("still full", cpu_stall, 1);
        mem_ready = 1;
        #1 chk("pop does not unblock", cpu_stall, 1);
        tick();
        #1 chk("accepted after pop", cpu_stall, 0);
        tick();
        cpu_we = 0;
        wait_drain();
        chk("fill write count", wlog.size() - w0, 5);
        if (wlog.size() >= w0 + 5) begin
            for (int j = 0; j < 5; j++) begin
                e = wlog[w0 + j];
                chk("fill wlog addr", e.a, 32'h100 + 32'(4 * j));
                chk("fill wlog data", e.d, 32'h10000000 + 32'(j));
            end
        end

        // Two stores to one word, then a forwarded load.
        w0 = wlog.size();
        mem_ready = 0;
        cpu_we = 1; cpu_addr = 32'h200; cpu_wdata = 32'hDEADBEEF;
        #1 chk("dup store 1 no stall", cpu_stall, 0);
        tick();
        cpu_wdata = 32'h12345678;
        #1 chk("dup store 2 no stall", cpu_stall, 0);
        tick();
        cpu_we = 0; cpu_re = 1; cpu_addr = 32'h202;
        #1 chk("fwd no stall", cpu_stall, 0);
        chk("fwd newest data", cpu_rdata, 32'h12345678);
        tick();
        cpu_re = 0;
        #1;
`ifdef WB_COALESCE_EN
        chk("in-flight head data", mem_wdata, 32'h12345678);
`else
        chk("in-flight head data", mem_wdata, 32'hDEADBEEF);
`endif
        mem_ready = 1;
        wait_drain();
`ifdef WB_COALESCE_EN
        chk("dup write count", wlog.size() - w0, 1);
`else
        chk("dup write count", wlog.size() - w0, 2);
`endif

        // Load miss from IDLE with a one-cycle memory.
        mem_ready = 1; cpu_re = 1; cpu_addr = 32'h300;
        #1 chk("miss stall", cpu_stall, 1);
        chk("miss rdata zero", cpu_rdata, 0);
        n = 0;
        while (cpu_stall && n < 10) begin
            tick();
            #1;
            n++;
        end
        chk("miss stall cycles", n, 1);
        chk("miss mem_req", mem_req, 1);
        chk("miss mem_we", mem_we, 0);
        chk("miss mem_addr", mem_addr, 32'h300);
        chk("miss rdata", cpu_rdata, 32'hCAFEF00D);
        tick();
        cpu_re = 0;

        // Load miss behind an in-flight write.
        mem_ready = 0;
        cpu_we = 1; cpu_addr = 32'h400; cpu_wdata = 32'h44440000;
        #1 tick();
        cpu_addr = 32'h404; cpu_wdata = 32'h44440004;
        #1 tick();
        cpu_we = 0; cpu_re = 1; cpu_addr = 32'h500;
        for (int k = 0; k < 3; k++) begin
            #1 chk("wr-miss stall", cpu_stall, 1);
            chk("wr-miss held addr", mem_addr, 32'h400);
            chk("wr-miss held we", mem_we, 1);
            tick();
        end
        mem_ready = 1;
        #1 chk("wr done still stall", cpu_stall, 1);
        chk("wr done addr", mem_addr, 32'h400);
        tick();
        #1 chk("read after write addr", mem_addr, 32'h500);
        chk("read after write we", mem_we, 0);
        chk("read after write stall", cpu_stall, 0);
        chk("read after write rdata", cpu_rdata, 32'h55550000);
        tick();
        cpu_re = 0;
        #1 chk("queued write addr", mem_addr, 32'h404);
        chk("queued write we", mem_we, 1);
        chk("queued write req", mem_req, 1);
        wait_drain();

        // Load hitting the entry popped in the same cycle.
        mem_ready = 0;
        cpu_we = 1; cpu_addr = 32'h900; cpu_wdata = 32'h99990000;
        #1 tick();
        cpu_we = 0;
        #1 tick();
        cpu_re = 1; cpu_addr = 32'h900; mem_ready = 1;
        #1 chk("pop-hit no stall", cpu_stall, 0);
        chk("pop-hit data", cpu_rdata, 32'h99990000);
        tick();
        cpu_re = 0;
        wait_drain();

        // Asynchronous reset in the middle of a write.
        mem_ready = 0;
        for (int j = 0; j < 3; j++) begin
            cpu_we = 1; cpu_addr = 32'h600 + 32'(4 * j); cpu_wdata = 32'hAAAA0600 + 32'(4 * j);
            #1 tick();
        end
        cpu_we = 0;
        #1 chk("pre-reset mem_req", mem_req, 1);
        chk("pre-reset mem_addr", mem_addr, 32'h600);
        #1 reset = 1'b0;
        #1 chk("async mem_req drop", mem_req, 0);
        chk("async mem_we", mem_we, 0);
        chk("async mem_addr", mem_addr, 0);
        chk("async stall", cpu_stall, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        w0 = wlog.size();
        mem_ready = 1; cpu_re = 1; cpu_addr = 32'h604;
        #1 chk("post-reset miss", cpu_stall, 1);
        tick();
        #1 chk("post-reset read stall", cpu_stall, 0);
        chk("post-reset read addr", mem_addr, 32'h604);
        chk("post-reset read data", cpu_rdata, 32'h66660004);
        tick();
        cpu_re = 0;
        repeat (3) tick();
        chk("discarded stores", wlog.size() - w0, 0);
        chk("idle after reset", mem_req, 0);

        // Pointer wrap: ten bursts of three stores, each drained.
        w0 = wlog.size();
        for (int it = 0; it < 10; it++) begin
            mem_ready = it[0];
            for (int j = 0; j < 3; j++) begin
                cpu_we = 1;
                cpu_addr = 32'h800 + 32'((it * 3 + j) * 4);
                cpu_wdata = 32'hB0000000 + 32'(it * 16 + j);
                #1 chk("wrap store no stall", cpu_stall, 0);
                tick();
            end
            cpu_we = 0;
            mem_ready = 1;
            wait_drain();
        end
        chk("wrap write count", wlog.size() - w0, 30);
        if (wlog.size() >= w0 + 30) begin
            for (int it = 0; it < 10; it++) begin
                for (int j = 0; j < 3; j++) begin
                    e = wlog[w0 + it * 3 + j];
                    chk("wrap wlog addr", e.a, 32'h800 + 32'((it * 3 + j) * 4));
                    chk("wrap wlog data", e.d, 32'hB0000000 + 32'(it * 16 + j));
                end
            end
        end
        chk("wrap backing memory", memarr[(32'h800 + 32'(29 * 4)) >> 2], 32'hB0000092);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted-write buffer between the single-cycle MIPS core's data port and a variable-latency data memory. Stores are queued and the core is not stalled. The queue drains to memory in the background. Loads are forwarded from the queue when possible and otherwise read from memory while the core is stalled. It replaces the direct core-to-`sram` connection in the top level, and the core holds its PC while `cpu_stall` is high.

## Interface
- `DEPTH`, default 4: number of store entries; power of two, ≥2.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: **one clock; reset is asynchronous and active-low**. The buffer is in reset while `reset`=0.
- `cpu_addr` input, 32 bits: byte address from the core's ALU result. Bits [1:0] are ignored (word access only).
- `cpu_wdata` input, 32 bits: store data.
- `cpu_we` input, 1 bit: store (`sw`) this cycle.
- `cpu_re` input, 1 bit: load (`lw`) this cycle. `cpu_we` and `cpu_re` are never both 1.
- `cpu_rdata` output, 32 bits: load data. Valid in the cycle where `cpu_re`=1 and `cpu_stall`=0. Otherwise 0.
- `cpu_stall` output, 1 bit: combinational. Tells the core to hold PC and all architectural writes.
- `mem_req` output, 1 bit: registered. Memory request valid.
- `mem_we` output, 1 bit: registered. 1 = write request, 0 = read request.
- `mem_addr` output, 32 bits: registered word-aligned address. Bits [1:0] are always 0.
- `mem_wdata` output, 32 bits: registered write data.
- `mem_ready` input, 1 bit: the request completes in this cycle. For reads, `mem_rdata` is valid in this same cycle.
- `mem_rdata` input, 32 bits: read data.

## Operation
**Storage.** The buffer is a circular FIFO of {addr[31:2], data}. It uses head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
- full = (count==DEPTH).
- empty = (count==0).

**Stores.** A store is accepted at the clock edge when `cpu_we`=1 and not full.
- An accepted store is written at the tail and the tail advances.
- If the buffer is full, `cpu_stall`=1. A slot freed by a pop in the same cycle does not unblock the store; it is accepted on the next cycle.

**Loads.** Match = entry addr[31:2] equal to `cpu_addr`[31:2].
- Hit: the newest matching entry supplies `cpu_rdata` combinationally, with no stall.
- An entry being popped in the same cycle still counts as a hit.
- Miss: `cpu_stall`=1 until the read completes.

**FSM states: IDLE, WRITE, READ.**
- **IDLE**
  - If a load miss is present, load {`cpu_addr`[31:2],2'b00} into `mem_addr`, set `mem_req`=1 and `mem_we`=0, and go to READ.
  - Else, if not empty, load the head entry into the mem outputs, set `mem_req`=1 and `mem_we`=1, and go to WRITE.
  - Else, stay in IDLE with `mem_req`=0.
- **WRITE**
  - Mem outputs are held stable until `mem_ready`.
  - On `mem_ready`, pop the head.
  - The next state is chosen with IDLE priority: load miss → READ, else remaining count>0 → WRITE with the next head, else IDLE.
  - Remaining count means count after the pop, plus any same-cycle store.
- **READ**
  - Mem outputs are held stable until `mem_ready`.
  - On `mem_ready`: `cpu_rdata`=`mem_rdata`, `cpu_stall`=0, then go to IDLE, or directly to WRITE if not empty.
- Read misses take priority over draining only at request-issue points. An in-flight write is never aborted.
- A store and a pop in the same cycle leave count unchanged.
- `cpu_stall` = (`cpu_we` & full) | (`cpu_re` & ~hit & ~(state==READ & `mem_ready`)).

**Reset** (asynchronous, mid-operation included):
- count=0, head=tail=0, state=IDLE.
- `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Queued stores and any in-flight request are discarded.
- While `reset`=0, `cpu_stall`=0 and `cpu_rdata`=0.

## Timing
- Store: zero-cycle cost to the core unless the buffer is full.
- Load hit: zero-cycle cost.
- Load miss from IDLE with a 1-cycle memory:
  - miss cycle: IDLE, stall=1;
  - next cycle: READ with `mem_ready`, stall=0.
  - The core loses exactly 1 cycle.
- Load miss during WRITE: the stall also covers the remaining write cycles, plus 1.
- Drain throughput with an always-ready memory: one entry per cycle once in WRITE.
- `mem_*` outputs change only on clock edges.

## Configuration
- `WB_COALESCE_EN` defined:
  - A store whose word address matches a queued entry overwrites that entry's data in place. Count does not change, and the store does not stall even when full.
  - Exception: if the match is the head while state==WRITE (head in flight), the store appends normally instead.
- `WB_COALESCE_EN` undefined:
  - Every store appends, and duplicate addresses can coexist.
  - Forwarding uses the newest match.

## Test plan
- Reset, then 4 stores to 0x100/0x104/0x108/0x10C with `mem_ready`=0 → no stall, count=4. A 5th store to 0x110 → `cpu_stall`=1. Raise `mem_ready` → the 0x100 write completes, and the 0x110 store is accepted on the following cycle.
- Store 0xDEADBEEF to 0x200, then store 0x12345678 to 0x200, then load 0x202 → `cpu_rdata`=0x12345678 with no stall, for both macro settings. Without the macro, count=2; with it, count=1.
- Empty buffer, load 0x300, memory returns 0xCAFEF00D with 1-cycle ready → stall for exactly 1 cycle, `mem_we`=0, `mem_addr`=0x300, `cpu_rdata`=0xCAFEF00D.
- Write to 0x400 in flight (`mem_ready` held 0 for 3 cycles) plus a load miss to 0x500 → `mem_addr` stays 0x400 until ready, then 0x500 is read. A queued write to 0x404 is issued only after the read completes.
- Pull `reset` low mid-WRITE with 3 entries queued → `mem_req` drops asynchronously to 0, and count=0 after release. A load of a previously buffered address then misses and goes to memory.
- Head/tail wrap: 10 store/drain cycles with DEPTH=4 → memory receives writes in exact program order and data, and count ends at 0.
